// File: rtl/jt49_pkg.sv
// Shared constants and types for the envelope generator: ctrl bit positions,
// level width and the two-state FSM encoding.
package jt49_pkg;

    localparam int CTRL_CONT = 3;
    localparam int CTRL_ATT  = 2;
    localparam int CTRL_ALT  = 1;
    localparam int CTRL_HOLD = 0;

    localparam int          ENV_W    = 5;
    localparam logic [4:0]  SCNT_MAX = 5'd31;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } env_state_t;

    // Output level is the step count, optionally mirrored for a falling slope.
    function automatic logic [4:0] env_level(input logic [4:0] scnt, input logic inv);
        return scnt ^ {5{inv}};
    endfunction

endpackage

// File: rtl/jt49_env_div.sv
// Envelope period divider: counts cen256 ticks and emits a tick when the
// programmed period (0 treated as 1) is reached.
module jt49_env_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen256,
    input  logic [15:0] period,
    input  logic        clr,
    output logic        tick
);

    logic [15:0] pcnt;
    logic [16:0] pnext;
    logic [16:0] plim;
    logic        reach;

    // 17-bit compare: a period lowered below pcnt fires at once instead of wrapping.
    always_comb begin
        pnext = {1'b0, pcnt} + 17'd1;
        plim  = (period == 16'd0) ? 17'd1 : {1'b0, period};
        reach = (pnext >= plim);
        tick  = cen256 & ~clr & reach;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= 16'd0;
        end else if (clr) begin
            pcnt <= 16'd0;
        end else if (cen256) begin
            pcnt <= reach ? 16'd0 : pnext[15:0];
        end
    end

endmodule

// File: rtl/jt49_envelope.sv
// AY/YM-style envelope generator: period divider plus RUN/HOLD shape FSM.
//   state   | meaning
//   ST_RUN  | step counter advances on each divider tick
//   ST_HOLD | envelope frozen; divider still runs, no step pulses
module jt49_envelope
    import jt49_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen256,
    input  logic [15:0] period,
    input  logic [3:0]  ctrl,
    input  logic        restart,
    output logic [4:0]  env,
    output logic        step,
    output logic        held
);

    env_state_t  state, state_nx;
    logic [4:0]  scnt, scnt_nx;
    logic        inv, inv_nx;
    logic [4:0]  env_nx;
    logic        step_nx;
    logic        tick;

    jt49_env_div u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen256 (cen256),
        .period (period),
        .clr    (restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HOLD;
            scnt  <= 5'd0;
            inv   <= 1'b0;
            env   <= 5'd0;
            step  <= 1'b0;
        end else begin
            state <= state_nx;
            scnt  <= scnt_nx;
            inv   <= inv_nx;
            env   <= env_nx;
            step  <= step_nx;
        end
    end

    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        inv_nx   = inv;
        env_nx   = env;
        step_nx  = 1'b0;
        if (restart) begin
            scnt_nx  = 5'd0;
            inv_nx   = ~ctrl[CTRL_ATT];
            state_nx = ST_RUN;
            env_nx   = env_level(5'd0, inv_nx);
        end else if (tick && state == ST_RUN) begin
            step_nx = 1'b1;
            if (scnt != SCNT_MAX) begin
                scnt_nx = scnt + 5'd1;
            end else if (!ctrl[CTRL_CONT]) begin
                state_nx = ST_HOLD;
            end else begin
                if (ctrl[CTRL_ALT])
                    inv_nx = ~inv;
                if (ctrl[CTRL_HOLD])
                    state_nx = ST_HOLD;
                else
                    scnt_nx = 5'd0;
            end
            // One-shot shapes park at zero; continuous holds keep the last level.
            env_nx = (state_nx == ST_HOLD && !ctrl[CTRL_CONT]) ? 5'd0
                                                               : env_level(scnt_nx, inv_nx);
        end
    end

    assign held = (state == ST_HOLD);

endmodule
